// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single UART transmitter.
// Hands one byte at a time to the transmitter and aborts a transfer if tx_done never arrives.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_byte,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_byte,
    output logic       req1_ready,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_ready,
    input  logic       tx_done,
    output logic       grant,
    output logic [1:0] state_out,
    output logic       timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 32'd1) ? 1 : $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             timeout_s;
    logic             win_s;
    logic             offer_s;
    logic [7:0]       win_byte_s;
    logic [7:0]       tx_byte_r;
    logic             tx_dv_r;
    logic             grant_r;
    logic             last_grant_r;
    logic             timeout_err_r;

    // Arbitration: pick the winner and raise its ready only while idle, out of reset and tx is free.
    always_comb begin
        win_s = 1'b0;
        if (req0_valid && req1_valid) begin
            win_s = ~last_grant_r;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        offer_s    = (state_r == ST_IDLE) && tx_ready && (req0_valid || req1_valid) && !rst;
        req0_ready = offer_s && !win_s;
        req1_ready = offer_s && win_s;
        win_byte_s = win_s ? req1_byte : req0_byte;
    end

    // Next-state and timeout counter logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (offer_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_nxt_s = ST_WAIT;
                cnt_nxt_s   = CNT_ZERO;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    // TIMEOUT_CYCLES cycles spent in WAIT: give up on this frame.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Control state: FSM, timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (timeout_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    // Datapath: capture the accepted byte and owner; tx_dv is high exactly in the SEND cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte_r    <= 8'h00;
            tx_dv_r      <= 1'b0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            tx_dv_r <= offer_s;
            if (offer_s) begin
                tx_byte_r    <= win_byte_s;
                grant_r      <= win_s;
                last_grant_r <= win_s;
            end
        end
    end

    assign tx_dv       = tx_dv_r;
    assign tx_byte     = tx_byte_r;
    assign grant       = grant_r;
    assign state_out   = state_r;
    assign timeout_err = timeout_err_r;

endmodule
